// File: rtl/axis_framer_pkg.sv
// Shared types and helpers for the AXI-Stream packet framer.
// Holds the framer state encoding and the index-width helper.
package axis_framer_pkg;

    typedef enum logic {
        StPayload = 1'b0,
        StTrailer = 1'b1
    } frm_state_e;

    // Ceiling log2 with a floor of 1 so PKT_LEN=1 still yields a legal vector.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while (w < 32 && (32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered stream slice; in_ready is registered so the upstream
// ready path never sees the downstream ready combinationally.
module axis_skid_reg #(
    parameter int unsigned DATA_WIDTH = 33
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_valid;

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_skid_valid) begin
            if (i_ready || !r_main_valid) begin
                r_main_valid <= i_valid;
                if (i_valid) begin
                    r_main_data <= i_data;
                end
            end else if (i_valid) begin
                // Output stalled: park the accepted word in the second entry.
                r_skid_data  <= i_data;
                r_skid_valid <= 1'b1;
            end
        end else if (i_ready) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
        end
    end

    assign o_ready = !r_skid_valid;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule

// File: rtl/axis_pkt_framer.sv
// Frames a word stream into PKT_LEN-word packets, each followed by an XOR
// checksum trailer flagged with m_last; counts delivered packets.
module axis_pkt_framer
    import axis_framer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PKT_LEN    = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    localparam int unsigned    IdxW    = clog2(PKT_LEN);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_LEN - 1);

    frm_state_e            r_state;
    frm_state_e            w_state_d;
    logic [IdxW-1:0]       r_index;
    logic [DATA_WIDTH-1:0] r_csum;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic [DATA_WIDTH:0]   w_skid_data;
    logic                  w_skid_valid;
    logic                  w_skid_in_ready;
    logic [DATA_WIDTH:0]   w_out_data;
    logic                  w_out_valid;
    logic                  w_s_ready;
    logic                  w_pay_acc;
    logic                  w_trl_acc;

    always_comb begin
        w_state_d    = r_state;
        w_skid_data  = {1'b0, s_data};
        w_skid_valid = 1'b0;
        w_s_ready    = 1'b0;
        w_pay_acc    = 1'b0;
        w_trl_acc    = 1'b0;
        case (r_state)
            StPayload: begin
                w_skid_valid = s_valid;
                w_s_ready    = w_skid_in_ready;
                w_pay_acc    = s_valid && w_skid_in_ready;
                if (w_pay_acc && r_index == LastIdx) begin
                    w_state_d = StTrailer;
                end
            end
            StTrailer: begin
                w_skid_data  = {1'b1, r_csum};
                w_skid_valid = 1'b1;
                w_trl_acc    = w_skid_in_ready;
                if (w_trl_acc) begin
                    w_state_d = StPayload;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_state     <= StPayload;
            r_index     <= '0;
            r_csum      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_pay_acc) begin
                r_index <= (r_index == LastIdx) ? '0 : r_index + IdxW'(1);
                r_csum  <= r_csum ^ s_data;
            end else if (w_trl_acc) begin
                r_csum <= '0;
            end
            if (w_out_valid && m_ready && w_out_data[DATA_WIDTH]) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_data  (w_skid_data),
        .i_valid (w_skid_valid),
        .o_ready (w_skid_in_ready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid),
        .i_ready (m_ready)
    );

    assign s_ready   = w_s_ready;
    assign m_data    = w_out_data[DATA_WIDTH-1:0];
    assign m_valid   = w_out_valid;
    // The held last bit outlives the beat it belonged to, so qualify it.
    assign m_last    = w_out_data[DATA_WIDTH] && w_out_valid;
    assign pkt_count = r_pkt_count;
    // A full second entry shows up as in_ready low.
    assign busy      = (r_index != '0) || (r_state == StTrailer) || w_out_valid
                       || !w_skid_in_ready;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Directed bench for axis_pkt_framer: one PKT_LEN=4 instance for framing,
// backpressure, random and reset cases; one PKT_LEN=1/CNT_WIDTH=2 instance.
module tb_axis_pkt_framer;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] pkt_count;
    logic        busy;

    logic [31:0] b_s_data;
    logic        b_s_valid;
    logic        b_s_ready;
    logic [31:0] b_m_data;
    logic        b_m_valid;
    logic        b_m_ready;
    logic        b_m_last;
    logic [1:0]  b_pkt_count;
    logic        b_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    logic        r_prev_stall;
    logic [32:0] r_prev_beat;

    logic [31:0] mx;
    int          mn;

    axis_pkt_framer #(
        .DATA_WIDTH (32),
        .PKT_LEN    (4),
        .CNT_WIDTH  (16)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    axis_pkt_framer #(
        .DATA_WIDTH (32),
        .PKT_LEN    (1),
        .CNT_WIDTH  (2)
    ) dut_b (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_data    (b_s_data),
        .s_valid   (b_s_valid),
        .s_ready   (b_s_ready),
        .m_data    (b_m_data),
        .m_valid   (b_m_valid),
        .m_ready   (b_m_ready),
        .m_last    (b_m_last),
        .pkt_count (b_pkt_count),
        .busy      (b_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records every delivered beat and checks stall stability.
    always @(posedge aclk) begin
        if (!aresetn) begin
            if (r_prev_stall) begin
                check("hold_stable", {31'd0, m_valid, m_last, m_data}, {31'd0, 1'b1, r_prev_beat});
            end
            r_prev_stall <= m_valid && !m_ready;
            r_prev_beat  <= {m_last, m_data};
            if (m_valid && m_ready) begin
                out_q.push_back({m_last, m_data});
            end
        end else begin
            r_prev_stall <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", {63'd0, s_ready}, 64'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] d);
        exp_q.push_back({1'b0, d});
        mx = mx ^ d;
        mn++;
        if (mn == 4) begin
            exp_q.push_back({1'b1, mx});
            mx = '0;
            mn = 0;
        end
    endtask

    task automatic drain_and_compare(input string tag);
        int n;
        n = 0;
        while (out_q.size() < exp_q.size() && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), {31'd0, out_q[i]}, {31'd0, exp_q[i]});
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [9:0]  pat;
        int          acc;
        int          cyc;
        logic        took;
        logic [31:0] bvals [5];
        logic [1:0]  bcnt  [5];

        aresetn   = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        m_ready   = 1'b1;
        b_s_data  = '0;
        b_s_valid = 1'b0;
        b_m_ready = 1'b1;
        mx        = '0;
        mn        = 0;
        repeat (3) tick();

        // Reset state
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_last", {63'd0, m_last}, 64'd0);
        check("rst_m_data", {32'd0, m_data}, 64'd0);
        check("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_b_pkt_count", {62'd0, b_pkt_count}, 64'd0);
        aresetn = 1'b0;
        tick();

        // Basic packet 1,2,3,4 -> trailer 4
        exp_q.push_back({1'b0, 32'h1});
        exp_q.push_back({1'b0, 32'h2});
        exp_q.push_back({1'b0, 32'h3});
        exp_q.push_back({1'b0, 32'h4});
        exp_q.push_back({1'b1, 32'h4});
        push(32'h1);
        check("busy_mid", {63'd0, busy}, 64'd1);
        push(32'h2);
        push(32'h3);
        push(32'h4);
        drain_and_compare("basic");
        check("basic_pkt_count", {48'd0, pkt_count}, 64'd1);
        check("basic_busy", {63'd0, busy}, 64'd0);

        // Continuous streaming: one forced bubble after every 4th accept
        acc = 0;
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            s_data  = 32'hA0 + 32'(acc);
            s_valid = 1'b1;
            pat[c]  = s_ready;
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        check("stream_ready_pattern", {54'd0, pat}, {54'd0, 10'b0111101111});
        check("stream_accepts", 64'(acc), 64'd8);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'hA0 + 32'(i)});
        exp_q.push_back({1'b1, 32'h0});
        for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 32'hA0 + 32'(i)});
        exp_q.push_back({1'b1, 32'h0});
        drain_and_compare("stream");
        check("stream_pkt_count", {48'd0, pkt_count}, 64'd3);

        // Backpressure: m_ready low for 6 cycles mid-packet
        exp_q.push_back({1'b0, 32'h10});
        exp_q.push_back({1'b0, 32'h20});
        exp_q.push_back({1'b0, 32'h40});
        exp_q.push_back({1'b0, 32'h80});
        exp_q.push_back({1'b1, 32'hF0});
        push(32'h10);
        push(32'h20);
        m_ready = 1'b0;
        s_data  = 32'h40;
        s_valid = 1'b1;
        acc     = 0;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("stall_valid%0d", c), {63'd0, m_valid}, 64'd1);
            check($sformatf("stall_data%0d", c), {32'd0, m_data}, 64'h20);
            took = s_ready;
            tick();
            if (took) begin
                acc++;
                s_data = 32'h80;
            end
        end
        check("stall_accepts", 64'(acc), 64'd1);
        check("stall_s_ready", {63'd0, s_ready}, 64'd0);
        m_ready = 1'b1;
        push(32'h80);
        drain_and_compare("stall");
        check("stall_pkt_count", {48'd0, pkt_count}, 64'd4);

        // Randomised valid/ready, 20 packets checked against the XOR model
        mx  = '0;
        mn  = 0;
        acc = 0;
        cyc = 0;
        while (acc < 80 && cyc < 3000) begin
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                s_data  = $urandom;
                s_valid = 1'b1;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            took    = s_valid && s_ready;
            if (took) begin
                model_accept(s_data);
                acc++;
            end
            tick();
            cyc++;
            if (took) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("rand_accepts", 64'(acc), 64'd80);
        drain_and_compare("rand");
        check("rand_pkt_count", {48'd0, pkt_count}, 64'd24);

        // Reset mid-packet discards the partial packet
        push(32'h1);
        push(32'h2);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        aresetn = 1'b1;
        #1;
        check("mid_rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("mid_rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        out_q.delete();
        exp_q.delete();
        tick();
        aresetn = 1'b0;
        tick();
        exp_q.push_back({1'b0, 32'h5});
        exp_q.push_back({1'b0, 32'h6});
        exp_q.push_back({1'b0, 32'h7});
        exp_q.push_back({1'b0, 32'h8});
        exp_q.push_back({1'b1, 32'hC});
        push(32'h5);
        push(32'h6);
        push(32'h7);
        push(32'h8);
        drain_and_compare("post_rst");
        check("post_rst_pkt_count", {48'd0, pkt_count}, 64'd1);

        // PKT_LEN=1, CNT_WIDTH=2: trailer equals word, counter wraps
        bvals[0] = 32'h11;
        bvals[1] = 32'h22;
        bvals[2] = 32'hDEADBEEF;
        bvals[3] = 32'h0;
        bvals[4] = 32'h5A5A5A5A;
        bcnt[0]  = 2'd1;
        bcnt[1]  = 2'd2;
        bcnt[2]  = 2'd3;
        bcnt[3]  = 2'd0;
        bcnt[4]  = 2'd1;
        for (int k = 0; k < 5; k++) begin
            b_s_data  = bvals[k];
            b_s_valid = 1'b1;
            cyc = 0;
            while (!b_s_ready && cyc < 20) begin
                tick();
                cyc++;
            end
            check($sformatf("b_ready%0d", k), {63'd0, b_s_ready}, 64'd1);
            tick();
            b_s_valid = 1'b0;
            check($sformatf("b_word_valid%0d", k), {63'd0, b_m_valid}, 64'd1);
            check($sformatf("b_word%0d", k), {31'd0, b_m_last, b_m_data}, {31'd0, 1'b0, bvals[k]});
            tick();
            check($sformatf("b_trl_valid%0d", k), {63'd0, b_m_valid}, 64'd1);
            check($sformatf("b_trl%0d", k), {31'd0, b_m_last, b_m_data}, {31'd0, 1'b1, bvals[k]});
            tick();
            check($sformatf("b_cnt%0d", k), {62'd0, b_pkt_count}, {62'd0, bcnt[k]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
